// File: rtl/note_scheduler_pkg.sv
// Shared types and constants for the piano note scheduler: FSM states,
// song ROM word layout and the silent note code.
package note_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY_PLAY,
    FETCH_WAIT,
    FETCH_LOAD,
    SONG_NOTE,
    SONG_GAP
  } state_t;

  localparam int CODE_MSB = 11;
  localparam int CODE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  localparam logic [7:0] SILENT = 8'h00;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..v inclusive.
  function automatic int width_for(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/note_scheduler_tick_timer.sv
// Prescaler plus tick down-counter shared by note, gap and key-hold timing.
// A start pulse makes its own cycle act as prescaler phase 0 with the new load.
module note_scheduler_tick_timer #(
  parameter int TICK_DIV = 50000,
  parameter int TW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [TW-1:0] load,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_eff;
  logic [TW-1:0] rem_q;
  logic [TW-1:0] rem_eff;
  logic          tick;

  always_comb begin
    pre_eff = start ? '0 : pre_q;
    rem_eff = start ? load : rem_q;
    tick    = (pre_eff == PW'(TICK_DIV - 1));
    done    = tick && (rem_eff == TW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      rem_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_eff + 1'b1;
      if (tick && (rem_eff != '0)) begin
        rem_q <= rem_eff - 1'b1;
      end else begin
        rem_q <= rem_eff;
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Chooses between live key notes and ROM song playback for the buzzer,
// display and ring enable; live keys always pre-empt the song.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter  int SONG_LEN       = 32,
  parameter  int TICK_DIV       = 50000,
  parameter  int UNIT_TICKS     = 125,
  parameter  int GAP_TICKS      = 20,
  parameter  int KEY_HOLD_UNITS = 2,
  localparam int AW             = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iKeyValid,
  input  logic [7:0]    iKeyCode,
  input  logic          iPlayReq,
  input  logic          iStopReq,
  output logic [AW-1:0] oRomAddr,
  input  logic [11:0]   iRomData,
  output logic [7:0]    oFreqType,
  output logic          oRing,
  output logic          oBusy,
  output logic          oSource
);

  localparam int MAX_TICKS = max3(15 * UNIT_TICKS, GAP_TICKS, KEY_HOLD_UNITS * UNIT_TICKS);
  localparam int TW        = width_for(MAX_TICKS);

  localparam logic [TW-1:0] KEY_HOLD_TICKS = TW'(KEY_HOLD_UNITS * UNIT_TICKS);
  localparam logic [TW-1:0] GAP_LOAD       = TW'(GAP_TICKS);
  localparam logic [TW-1:0] UNIT_LOAD      = TW'(UNIT_TICKS);
  localparam logic [AW-1:0] LAST_ADDR      = AW'(SONG_LEN - 1);

  state_t        state;
  logic          timer_start;
  logic [TW-1:0] timer_load;
  logic          timer_done;

  logic          key_on;
  logic          key_off;
  logic [7:0]    rom_code;
  logic [3:0]    rom_dur;

  always_comb begin
    key_on   = iKeyValid && (iKeyCode != SILENT);
    key_off  = iKeyValid && (iKeyCode == SILENT);
    rom_code = iRomData[CODE_MSB:CODE_LSB];
    rom_dur  = iRomData[DUR_MSB:DUR_LSB];
  end

  note_scheduler_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW)
  ) u_timer (
    .clk   (iClk),
    .rst_n (iReset_n),
    .start (timer_start),
    .load  (timer_load),
    .done  (timer_done)
  );

  // Outputs are registered together with the state they belong to, so every
  // transition is visible on the outputs right after its clock edge.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= IDLE;
      oFreqType   <= SILENT;
      oRing       <= 1'b0;
      oBusy       <= 1'b0;
      oSource     <= 1'b0;
      oRomAddr    <= '0;
      timer_start <= 1'b0;
      timer_load  <= '0;
    end else begin
      timer_start <= 1'b0;
      if (iStopReq) begin
        state     <= IDLE;
        oFreqType <= SILENT;
        oRing     <= 1'b0;
        oBusy     <= 1'b0;
        oSource   <= 1'b0;
      end else if (key_on) begin
        state       <= KEY_PLAY;
        oFreqType   <= iKeyCode;
        oRing       <= 1'b1;
        oBusy       <= 1'b0;
        oSource     <= 1'b0;
        oRomAddr    <= '0;
        timer_start <= 1'b1;
        timer_load  <= KEY_HOLD_TICKS;
      end else if (iPlayReq && (state != KEY_PLAY)) begin
        state     <= FETCH_WAIT;
        oFreqType <= SILENT;
        oRing     <= 1'b0;
        oBusy     <= 1'b1;
        oSource   <= 1'b1;
        oRomAddr  <= '0;
      end else begin
        case (state)
          IDLE: begin
          end
          KEY_PLAY: begin
            if (key_off || timer_done) begin
              state     <= IDLE;
              oFreqType <= SILENT;
              oRing     <= 1'b0;
              oSource   <= 1'b0;
            end
          end
          FETCH_WAIT: begin
            state <= FETCH_LOAD;
          end
          // A zero duration marks the end of the song.
          FETCH_LOAD: begin
            if (rom_dur == 4'd0) begin
              state     <= IDLE;
              oFreqType <= SILENT;
              oRing     <= 1'b0;
              oBusy     <= 1'b0;
              oSource   <= 1'b0;
            end else begin
              state       <= SONG_NOTE;
              oFreqType   <= rom_code;
              oRing       <= (rom_code != SILENT);
              timer_start <= 1'b1;
              timer_load  <= TW'(rom_dur) * UNIT_LOAD;
            end
          end
          SONG_NOTE: begin
            if (timer_done) begin
              state       <= SONG_GAP;
              oFreqType   <= SILENT;
              oRing       <= 1'b0;
              timer_start <= 1'b1;
              timer_load  <= GAP_LOAD;
            end
          end
          SONG_GAP: begin
            if (timer_done) begin
              if (oRomAddr == LAST_ADDR) begin
                state   <= IDLE;
                oBusy   <= 1'b0;
                oSource <= 1'b0;
              end else begin
                state    <= FETCH_WAIT;
                oRomAddr <= oRomAddr + 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            oFreqType <= SILENT;
            oRing     <= 1'b0;
            oBusy     <= 1'b0;
            oSource   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
